// File: rtl/min_scheduler_pkg.sv
// min_scheduler_pkg
//   Shared types and default sizes for the minimum-conflict network scheduler.
//   Contents: FSM state enum, default port count / control width / burst
//   limit, and the width of the in-flight word counter.
package min_scheduler_pkg;

    localparam int NPORTS_DEF    = 16;
    localparam int CTRL_W_DEF    = 4;
    localparam int BURST_MAX_DEF = 8;
    localparam int INFLIGHT_W    = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/min_scheduler_if.sv
// min_scheduler_if
//   Bundles the requester / network handshake of the scheduler.
//   req       requester i has a word waiting (held until granted)
//   req_dest  destination of requester i, requester 0 in the top CTRL_W bits
//   valid     network output valid, one bit per output lane
//   push      word on network input lane i consumed this cycle
//   grant     same as push, tells requester i to advance
//   control   network permutation: source i routes to i XOR control
//   busy      words in flight or scheduler not idle
//   Modports: master = requesters + network, slave = scheduler.
interface min_scheduler_if import min_scheduler_pkg::*; #(
    parameter int NPORTS = NPORTS_DEF,
    parameter int CTRL_W = CTRL_W_DEF
) ();

    logic [0:NPORTS-1]        req;
    logic [NPORTS*CTRL_W-1:0] req_dest;
    logic [0:NPORTS-1]        valid;
    logic [0:NPORTS-1]        push;
    logic [0:NPORTS-1]        grant;
    logic [CTRL_W-1:0]        control;
    logic                     busy;

    modport master (
        output req, req_dest, valid,
        input  push, grant, control, busy
    );

    modport slave (
        input  req, req_dest, valid,
        output push, grant, control, busy
    );

endinterface

// File: rtl/min_rr_pick.sv
// min_rr_pick
//   Round-robin selector over control values. Purely combinational.
//   pending  bit c set when some requester would be served by control c
//   rr_ptr   first control value to consider; search wraps modulo NPORTS
//   pick     lowest c >= rr_ptr (wrapping) with pending[c] set
//   any      at least one pending bit set
module min_rr_pick import min_scheduler_pkg::*; #(
    parameter int NPORTS = NPORTS_DEF,
    parameter int CTRL_W = CTRL_W_DEF
) (
    input  logic [0:NPORTS-1] pending,
    input  logic [CTRL_W-1:0] rr_ptr,
    output logic [CTRL_W-1:0] pick,
    output logic              any
);

    always_comb begin
        logic              found;
        logic [CTRL_W-1:0] idx;
        pick  = rr_ptr;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NPORTS; k++) begin
            // CTRL_W-bit add wraps naturally because NPORTS is a power of two
            idx = rr_ptr + CTRL_W'(k);
            if (!found && pending[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    assign any = |pending;

endmodule

// File: rtl/min_scheduler.sv
// min_scheduler
//   Picks an XOR permutation (control) for the network, pushes every
//   requester whose destination matches it, bounds bursts on one control
//   value and drains the network before switching permutation.
//   Ports:
//     clk, rst     clock, asynchronous active-high reset
//     bus          min_scheduler_if.slave (req/req_dest/valid in,
//                  push/grant/control/busy out)
//     stat_words   words issued, 32-bit wrapping     (MIN_SCHEDULER_STATS_EN)
//     stat_drain   cycles spent in DRAIN, wrapping   (MIN_SCHEDULER_STATS_EN)
//   Build option: define MIN_SCHEDULER_STATS_EN to add the statistics
//   counters and their ports.
//
//   state | meaning
//   IDLE  | nothing issued; pick a control value when requests appear
//   ISSUE | pushing every requester matching the registered control
//   DRAIN | pushes stopped, waiting for the network to empty
module min_scheduler import min_scheduler_pkg::*; #(
    parameter int NPORTS    = NPORTS_DEF,
    parameter int CTRL_W    = CTRL_W_DEF,
    parameter int BURST_MAX = BURST_MAX_DEF
) (
    input  logic        clk,
    input  logic        rst,
`ifdef MIN_SCHEDULER_STATS_EN
    output logic [31:0] stat_words,
    output logic [31:0] stat_drain,
`endif
    min_scheduler_if.slave bus
);

    localparam int BURST_W = $clog2(BURST_MAX + 1);
    localparam int SUM_W   = INFLIGHT_W + 2;
    localparam logic [SUM_W-1:0] INFLIGHT_MAX = SUM_W'((1 << INFLIGHT_W) - 1);

    state_t                state_q, state_d;
    logic [CTRL_W-1:0]     control_q, control_d;
    logic [CTRL_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [BURST_W-1:0]    burst_q, burst_d;
    logic [INFLIGHT_W-1:0] inflight_q, inflight_d;
    logic                  underflow_q, underflow_d;

    logic [CTRL_W-1:0]     dest [NPORTS];
    logic [0:NPORTS-1]     match_ctrl;
    logic [0:NPORTS-1]     pending;
    logic [0:NPORTS-1]     pending_other;
    logic [0:NPORTS-1]     push_int;
    logic [CTRL_W-1:0]     pick;
    logic                  pick_any;
    logic                  req_any;
    logic                  push_any;
    logic                  other_any;
    logic                  inflight_zero;
    logic [SUM_W-1:0]      n_push, n_valid, n_total;

    for (genvar g = 0; g < NPORTS; g++) begin : g_port
        assign dest[g]       = bus.req_dest[CTRL_W*(NPORTS-g)-1 -: CTRL_W];
        assign match_ctrl[g] = bus.req[g] && (dest[g] == (CTRL_W'(g) ^ control_q));
    end

    // A requester i is served by exactly one control value: dest ^ i.
    always_comb begin
        pending = '0;
        for (int i = 0; i < NPORTS; i++) begin
            if (bus.req[i]) begin
                pending[dest[i] ^ CTRL_W'(i)] = 1'b1;
            end
        end
        pending_other            = pending;
        pending_other[control_q] = 1'b0;
    end

    assign req_any       = |bus.req;
    assign other_any     = |pending_other;
    assign push_any      = |push_int;
    assign inflight_zero = (inflight_q == '0);

    min_rr_pick #(
        .NPORTS (NPORTS),
        .CTRL_W (CTRL_W)
    ) u_pick (
        .pending (pending),
        .rr_ptr  (rr_ptr_q),
        .pick    (pick),
        .any     (pick_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            control_q   <= '0;
            rr_ptr_q    <= '0;
            burst_q     <= '0;
            inflight_q  <= '0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            control_q   <= control_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_q     <= burst_d;
            inflight_q  <= inflight_d;
            underflow_q <= underflow_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        control_d = control_q;
        rr_ptr_d  = rr_ptr_q;
        burst_d   = burst_q;
        push_int  = '0;
        case (state_q)
            IDLE: begin
                // Words from an earlier burst may still be in flight after
                // requests dropped; only re-route once they are gone.
                if (pick_any && (inflight_zero || pick == control_q)) begin
                    control_d = pick;
                    burst_d   = '0;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                push_int = match_ctrl;
                // Saturate so a long uncontended burst cannot wrap back to 0.
                if (push_any && burst_q != BURST_W'(BURST_MAX)) begin
                    burst_d = burst_q + 1'b1;
                end
                if (!req_any) begin
                    state_d  = IDLE;
                    rr_ptr_d = control_q + 1'b1;
                    burst_d  = '0;
                end else if (!push_any ||
                             (burst_d == BURST_W'(BURST_MAX) && other_any)) begin
                    state_d  = DRAIN;
                    rr_ptr_d = control_q + 1'b1;
                    burst_d  = '0;
                end
            end
            DRAIN: begin
                if (!req_any) begin
                    state_d = IDLE;
                end else if (inflight_zero) begin
                    control_d = pick;
                    burst_d   = '0;
                    state_d   = ISSUE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Net push/valid in one step so simultaneous entry and exit cancel.
    always_comb begin
        n_push  = '0;
        n_valid = '0;
        for (int i = 0; i < NPORTS; i++) begin
            n_push  = n_push + SUM_W'(push_int[i]);
            n_valid = n_valid + SUM_W'(bus.valid[i]);
        end
        n_total     = SUM_W'(inflight_q) + n_push;
        underflow_d = underflow_q;
        inflight_d  = inflight_q;
        if (n_valid > n_total) begin
            inflight_d  = '0;
            underflow_d = 1'b1;
        end else if ((n_total - n_valid) > INFLIGHT_MAX) begin
            inflight_d = '1;
        end else begin
            inflight_d = INFLIGHT_W'(n_total - n_valid);
        end
    end

    assign bus.push    = push_int;
    assign bus.grant   = push_int;
    assign bus.control = control_q;
    assign bus.busy    = !inflight_zero || (state_q != IDLE);

`ifdef MIN_SCHEDULER_STATS_EN
    logic [31:0] words_issued;
    logic [31:0] drain_cycles;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            words_issued <= '0;
            drain_cycles <= '0;
        end else begin
            words_issued <= words_issued + 32'(n_push);
            drain_cycles <= drain_cycles + 32'(state_q == DRAIN);
        end
    end

    assign stat_words = words_issued;
    assign stat_drain = drain_cycles;
`endif

endmodule

// File: tb/tb_min_scheduler.sv
// tb_min_scheduler
//   Directed bench for min_scheduler. Requesters hold a word count and drop
//   req once all their words are granted; the network returns valids from a
//   bench-side in-flight count. Expected (control, push) pairs are queued as
//   each scenario is set up and popped whenever the DUT pushes.
module tb_min_scheduler;
    import min_scheduler_pkg::*;

    localparam int NP = 16;
    localparam int CW = 4;

    typedef struct packed {
        logic [CW-1:0] ctrl;
        logic [0:NP-1] vec;
    } exp_t;

    logic clk;
    logic rst;
`ifdef MIN_SCHEDULER_STATS_EN
    logic [31:0] stat_words;
    logic [31:0] stat_drain;
`endif

    min_scheduler_if #(.NPORTS(NP), .CTRL_W(CW)) bus ();

    min_scheduler #(
        .NPORTS    (NP),
        .CTRL_W    (CW),
        .BURST_MAX (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef MIN_SCHEDULER_STATS_EN
        .stat_words (stat_words),
        .stat_drain (stat_drain),
`endif
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            n_tests = 0;
    int            n_fail  = 0;
    exp_t          sb[$];
    int            words_left [NP];
    int            tb_net;
    int            prev_net;
    logic [CW-1:0] prev_ctrl;
    logic          last_busy;
    logic          ret_en;
    int            ret_lanes;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pc(input logic [0:NP-1] v);
        int n = 0;
        for (int i = 0; i < NP; i++) n += int'(v[i]);
        return n;
    endfunction

    function automatic int words_total();
        int n = 0;
        for (int i = 0; i < NP; i++) n += words_left[i];
        return n;
    endfunction

    task automatic set_dest(input int i, input logic [CW-1:0] d);
        bus.req_dest[CW*(NP-i)-1 -: CW] = d;
    endtask

    task automatic sb_push(input logic [CW-1:0] c, input logic [0:NP-1] v, input int times);
        exp_t e;
        e.ctrl = c;
        e.vec  = v;
        for (int k = 0; k < times; k++) sb.push_back(e);
    endtask

    task automatic apply_inputs();
        int n;
        for (int i = 0; i < NP; i++) bus.req[i] = (words_left[i] != 0);
        n = ret_en ? ((tb_net < ret_lanes) ? tb_net : ret_lanes) : 0;
        for (int i = 0; i < NP; i++) bus.valid[i] = (i < n);
    endtask

    task automatic clear_model();
        for (int i = 0; i < NP; i++) words_left[i] = 0;
        sb.delete();
        tb_net    = 0;
        prev_net  = 0;
        prev_ctrl = '0;
        bus.req   = '0;
        bus.valid = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // One clock: sample outputs at the falling edge, then advance inputs.
    task automatic cycle();
        logic [0:NP-1] p;
        logic [0:NP-1] v;
        exp_t          e;
        @(negedge clk);
        p         = bus.push;
        v         = bus.valid;
        last_busy = bus.busy;
        check("inflight", 32'(dut.inflight_q), 32'(tb_net));
        check("no_grant_without_req", 32'(bus.grant & ~bus.req), 32'd0);
        if (prev_net != 0) check("ctrl_hold_inflight", 32'(bus.control), 32'(prev_ctrl));
        if (p != '0) begin
            if (sb.size() == 0) begin
                check("unexpected_push", 32'(p), 32'd0);
            end else begin
                e = sb.pop_front();
                check("push", 32'(p), 32'(e.vec));
                check("grant", 32'(bus.grant), 32'(e.vec));
                check("control", 32'(bus.control), 32'(e.ctrl));
            end
        end
        prev_ctrl = bus.control;
        prev_net  = tb_net;
        tb_net    = tb_net + pc(p) - pc(v);
        @(posedge clk);
        #1;
        for (int i = 0; i < NP; i++) if (p[i] && words_left[i] != 0) words_left[i]--;
        apply_inputs();
    endtask

    task automatic run_until_idle(input string tag, input int budget);
        int   k;
        logic done;
        k    = 0;
        done = 1'b0;
        while (!done && k < budget) begin
            cycle();
            k++;
            done = (sb.size() == 0) && (words_total() == 0) && !last_busy;
        end
        check({tag, "_completed"}, 32'(done), 32'd1);
    endtask

    initial begin
        int k;
        rst          = 1'b1;
        bus.req      = '0;
        bus.req_dest = '0;
        bus.valid    = '0;
        ret_en       = 1'b1;
        ret_lanes    = NP;
        last_busy    = 1'b0;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // reset state
        @(negedge clk);
        check("rst_push", 32'(bus.push), 32'd0);
        check("rst_grant", 32'(bus.grant), 32'd0);
        check("rst_control", 32'(bus.control), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_state", 32'(dut.state_q), 32'(IDLE));
        check("rst_inflight", 32'(dut.inflight_q), 32'd0);
        check("rst_underflow", 32'(dut.underflow_q), 32'd0);
        @(posedge clk);
        #1;

        // identity: all 16 served by control 0 in a single cycle
        for (int i = 0; i < NP; i++) begin
            set_dest(i, CW'(i));
            words_left[i] = 1;
        end
        sb_push(4'd0, 16'hFFFF, 1);
        apply_inputs();
        run_until_idle("identity", 40);
        check("identity_state_idle", 32'(dut.state_q), 32'(IDLE));
`ifdef MIN_SCHEDULER_STATS_EN
        check("stat_words", stat_words, 32'd16);
`endif

        // two requesters sharing control 5 (0->5, 3->6); rr_ptr is now 1
        set_dest(0, 4'd5);
        set_dest(3, 4'd6);
        words_left[0] = 1;
        words_left[3] = 1;
        sb_push(4'd5, 16'h9000, 1);
        apply_inputs();
        run_until_idle("shared_c5", 40);

        // c=1 (0->1, four words) then c=2 (1->3); network holds until DRAIN
        set_dest(0, 4'd1);
        set_dest(1, 4'd3);
        words_left[0] = 4;
        words_left[1] = 1;
        ret_en = 1'b0;
        sb_push(4'd1, 16'h8000, 4);
        sb_push(4'd2, 16'h4000, 1);
        apply_inputs();
        k = 0;
        while (dut.state_q != DRAIN && k < 20) begin
            cycle();
            k++;
        end
        check("c1_reaches_drain", 32'(dut.state_q), 32'(DRAIN));
        check("c1_drain_inflight", 32'(dut.inflight_q), 32'd4);
        check("c1_drain_control", 32'(bus.control), 32'd1);
        ret_en    = 1'b1;
        ret_lanes = 1;
        apply_inputs();
        run_until_idle("drain_switch", 60);

        // burst limit: 12 on c=0 with 10 words each; c=7 joins after start
        ret_lanes = NP;
        for (int i = 0; i < 12; i++) begin
            set_dest(i, CW'(i));
            words_left[i] = 10;
        end
        set_dest(12, 4'd11);
        sb_push(4'd0, 16'hFFF0, 8);
        sb_push(4'd7, 16'h0008, 1);
        sb_push(4'd0, 16'hFFF0, 2);
        apply_inputs();
        cycle();
        words_left[12] = 1;
        apply_inputs();
        run_until_idle("burst_limit", 200);

        // valid with nothing in flight
        check("underflow_clear", 32'(dut.underflow_q), 32'd0);
        bus.valid = 16'h0001;
        @(posedge clk);
        #1;
        bus.valid = '0;
        check("underflow_sticky", 32'(dut.underflow_q), 32'd1);
        check("underflow_saturate", 32'(dut.inflight_q), 32'd0);

        // reset while issuing with three words in flight
        do_reset();
        check("rerst_underflow", 32'(dut.underflow_q), 32'd0);
        for (int i = 0; i < 3; i++) begin
            set_dest(i, CW'(i));
            words_left[i] = 2;
        end
        ret_en = 1'b0;
        sb_push(4'd0, 16'hE000, 1);
        apply_inputs();
        cycle();
        cycle();
        check("midrst_state_issue", 32'(dut.state_q), 32'(ISSUE));
        check("midrst_inflight", 32'(dut.inflight_q), 32'd3);
        check("midrst_sb_empty", 32'(sb.size()), 32'd0);
        rst = 1'b1;
        #1;
        check("midrst_push_drop", 32'(bus.push), 32'd0);
        check("midrst_grant_drop", 32'(bus.grant), 32'd0);
        check("midrst_inflight_clr", 32'(dut.inflight_q), 32'd0);
        clear_model();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("postrst_state", 32'(dut.state_q), 32'(IDLE));
        check("postrst_busy", 32'(bus.busy), 32'd0);
        check("postrst_push", 32'(bus.push), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/min_scheduler.md
MIN_SCHEDULER -- requirements
Module: min_scheduler

Interface
REQ-001 Parameter NPORTS, default 16, number of network ports; SHALL be a power of two.
REQ-002 Parameter CTRL_W, default 4, width of control; SHALL equal log2(NPORTS).
REQ-003 Parameter BURST_MAX, default 8, maximum consecutive issue cycles on one control value while other values have requests pending.
REQ-004 Ports: one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 req  input  [0:NPORTS-1]  requester i has a word waiting; held until granted.
REQ-008 req_dest  input  NPORTS*CTRL_W  destination of requester i, packed in bits [CTRL_W*(NPORTS-i)-1 -: CTRL_W].
REQ-009 valid  input  [0:NPORTS-1]  network output valid, used for in-flight accounting.
REQ-010 push  output  [0:NPORTS-1]  network push; word on d_in lane i consumed this cycle.
REQ-011 grant  output  [0:NPORTS-1]  equals push; requester i may advance.
REQ-012 control  output  CTRL_W  network permutation; source i routes to i XOR control.
REQ-013 busy  output  1  high when in-flight count is nonzero or state is not IDLE.

Function
REQ-014 match(c)[i] = req[i] AND (req_dest[i] == i XOR c).
REQ-015 States: IDLE, ISSUE, DRAIN.
REQ-016 IDLE: push=0; if any req, pick c by round-robin from rr_ptr, which is the lowest c >= rr_ptr with match(c) nonzero, wrapping to 0; load control=c, go to ISSUE the next cycle.
REQ-017 ISSUE: push = match(control), combinational from registered control; burst counter increments each cycle push is nonzero.
REQ-018 ISSUE to DRAIN: match(control)==0 while req nonzero, or burst==BURST_MAX and some match(c != control) is nonzero.
REQ-019 ISSUE to IDLE: req==0.
REQ-020 DRAIN: push=0, control held; when in-flight==0, pick next c with rr_ptr=control+1 (mod NPORTS) and go to ISSUE; if req==0, go to IDLE.
REQ-021 control SHALL never change while in-flight count is nonzero.
REQ-022 In-flight counter width SHALL be 8 bits; next = cur + popcount(push) - popcount(valid), computed in the same cycle. Simultaneous push and valid SHALL net correctly.
REQ-023 The counter SHALL saturate at 0; valid with count 0 sets sticky error flag underflow_q (internal, observable in simulation).
REQ-024 rr_ptr SHALL update to control+1 on every exit from ISSUE, so a control value with no pending matches is skipped.
REQ-025 Requests with no destination (req low) SHALL never be pushed; a requester is granted at most once per cycle.

Reset
REQ-026 On rst, asynchronously: state=IDLE, control=0, rr_ptr=0, burst=0, in-flight=0, underflow_q=0; push=grant=0; busy=0.
REQ-027 Reset mid-ISSUE SHALL drop pushes immediately; words already in the network are not tracked after reset.

Configuration
REQ-028 Macro MIN_SCHEDULER_STATS_EN defined: 32-bit wrapping counters words_issued (+popcount(push)) and drain_cycles (+1 per DRAIN cycle), cleared by rst, exposed as outputs stat_words and stat_drain.
REQ-029 Macro undefined: the counters and the stat_words/stat_drain ports SHALL be absent.

Structure
REQ-030 Package min_scheduler_pkg SHALL hold the state enum (IDLE, ISSUE, DRAIN), NPORTS/CTRL_W defaults, and the in-flight width constant.
REQ-031 Sub-module min_rr_pick: inputs pending [0:NPORTS-1] (bit c = |match(c)) and rr_ptr; outputs pick index and any; purely combinational.

Verification
REQ-032 Requesters 0-15 all with req_dest=i (identity): after reset, IDLE then control=0, push=16'hFFFF one cycle, then IDLE after req drops.
REQ-033 req[0] dest 5 and req[3] dest 6 (both control 5): push 16'h9000 in one cycle with control=5.
REQ-034 req[0] dest 1 (c=1) and req[1] dest 3 (c=2): issue c=1, DRAIN until four valid returns, then issue c=2; control never changes while in-flight>0.
REQ-035 Twelve requesters held on c=0 and one on c=7, BURST_MAX=8: after 8 push cycles on c=0, DRAIN, then c=7 is served before c=0 resumes.
REQ-036 Assert rst during ISSUE with in-flight=3: push=0 in the same cycle; after release, state=IDLE, busy=0.
REQ-037 With MIN_SCHEDULER_STATS_EN defined, the REQ-032 stimulus gives stat_words=16; without the macro, the build has no stat ports.
